// File: rtl/mvm_ctrl_pkg.sv
// Shared types and constants for the MVM job controller: lane types, FSM state
// encoding and the index-width helper.
package mvm_ctrl_pkg;

    localparam int NUM_LANES = 4;
    localparam int SN_W      = 4;

    typedef logic signed [SN_W-1:0] sn4_t;
    typedef sn4_t [NUM_LANES-1:0]   vec4_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_ARM,
        ST_RUN,
        ST_OUT
    } state_t;

    // Row index needs at least one bit even for single-row jobs.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_ctrl_wdog.sv
// Per-row watchdog: counts cycles the engine is armed/running and flags the
// cycle on which the budget of TIMEOUT cycles is used up.
module mvm_ctrl_wdog
    import mvm_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 31
) (
    input  logic i_clk_mvc,
    input  logic i_rst_mvc,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk_mvc) begin
        if (i_rst_mvc) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_count && !o_timeout) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The TIMEOUT-th counted cycle is the last one allowed.
    assign o_timeout = i_count && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mvm_ctrl.sv
// MVM job controller: accepts a job (x vector + NUM_W weight rows), launches the
// engine once per row, captures each row result and offers it downstream.
// Optional per-row watchdog is compiled in with MVM_CTRL_TIMEOUT_EN.
module mvm_ctrl
    import mvm_ctrl_pkg::*;
#(
    parameter  int NUM_W   = 4,
    parameter  int TIMEOUT = 31,
    localparam int IDX_W   = idx_width(NUM_W)
) (
    input  logic                  i_clk_mvc,
    input  logic                  i_rst_mvc,
    input  logic                  i_job_valid,
    output logic                  o_job_ready,
    input  vec4_t                 i_x_job,
    input  logic [NUM_W-1:0][3:0] i_w_job,
    output logic                  o_start_mvm,
    output vec4_t                 o_x_mvm,
    output logic [3:0]            o_w_mvm,
    input  logic                  i_ismvm,
    input  vec4_t                 i_wx_result,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output vec4_t                 o_res_data,
    output logic [IDX_W-1:0]      o_res_idx,
    output logic                  o_res_last,
    output logic                  o_err,
    output state_t                o_dbg_state
);

    if (NUM_W < 1 || NUM_W > 8 || TIMEOUT < 1) begin : g_param_err
        $error("mvm_ctrl: NUM_W must be 1..8 and TIMEOUT >= 1");
    end

    // Both job and result ports use valid/ready: a transfer happens on a rising
    // edge where valid && ready; a raised valid holds its payload stable until
    // that transfer, and ready never depends combinationally on valid.

    state_t                state_q, state_nxt;
    vec4_t                 x_q;
    logic [NUM_W-1:0][3:0] w_q;
    logic [IDX_W-1:0]      idx_q;
    vec4_t                 cap_q;
    logic                  is_last;
    logic                  in_flight;
    logic                  timeout;

    assign is_last   = (idx_q == IDX_W'(NUM_W - 1));
    assign in_flight = (state_q == ST_ARM) || (state_q == ST_RUN);

`ifdef MVM_CTRL_TIMEOUT_EN
    logic err_q;

    mvm_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_clk_mvc (i_clk_mvc),
        .i_rst_mvc (i_rst_mvc),
        .i_clear   (state_q == ST_LAUNCH),
        .i_count   (in_flight),
        .o_timeout (timeout)
    );

    always_ff @(posedge i_clk_mvc) begin
        if (i_rst_mvc) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && i_job_valid) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign timeout = 1'b0;
    assign o_err   = 1'b0;
`endif

    always_ff @(posedge i_clk_mvc) begin
        if (i_rst_mvc) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            w_q     <= '0;
            idx_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q == ST_IDLE && i_job_valid) begin
                x_q   <= i_x_job;
                w_q   <= i_w_job;
                idx_q <= '0;
            end
            // Sampling also on the ARM->RUN edge keeps a one-cycle busy burst
            // from leaving the row with no captured result.
            if (in_flight && i_ismvm) begin
                cap_q <= i_wx_result;
            end
            if (state_q == ST_OUT && i_res_ready && !is_last) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt   = state_q;
        o_job_ready = 1'b0;
        o_start_mvm = 1'b0;
        o_res_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_job_ready = !i_rst_mvc;
                if (i_job_valid) state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                o_start_mvm = 1'b1;
                state_nxt   = ST_ARM;
            end
            ST_ARM: begin
                if (timeout)      state_nxt = ST_IDLE;
                else if (i_ismvm) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (timeout)       state_nxt = ST_IDLE;
                else if (!i_ismvm) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                o_res_valid = 1'b1;
                if (i_res_ready) state_nxt = is_last ? ST_IDLE : ST_LAUNCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_x_mvm     = x_q;
    assign o_w_mvm     = w_q[idx_q];
    assign o_res_data  = cap_q;
    assign o_res_idx   = idx_q;
    assign o_res_last  = is_last;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed + randomized bench for mvm_ctrl with a reactive engine model and a
// row-result scoreboard computed from job contents.
module tb_mvm_ctrl;

    localparam int NUM_W   = 4;
    localparam int TIMEOUT = 31;
    localparam int IDX_W   = 2;

    logic                 i_clk_mvc = 1'b0;
    logic                 i_rst_mvc = 1'b1;
    logic                 i_job_valid = 1'b0;
    logic                 o_job_ready;
    logic [15:0]          i_x_job = '0;
    logic [NUM_W*4-1:0]   i_w_job = '0;
    logic                 o_start_mvm;
    logic [15:0]          o_x_mvm;
    logic [3:0]           o_w_mvm;
    logic                 i_ismvm = 1'b0;
    logic [15:0]          i_wx_result = '0;
    logic                 o_res_valid;
    logic                 i_res_ready = 1'b0;
    logic [15:0]          o_res_data;
    logic [IDX_W-1:0]     o_res_idx;
    logic                 o_res_last;
    logic                 o_err;
    mvm_ctrl_pkg::state_t o_dbg_state;

    mvm_ctrl #(
        .NUM_W   (NUM_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk_mvc   (i_clk_mvc),
        .i_rst_mvc   (i_rst_mvc),
        .i_job_valid (i_job_valid),
        .o_job_ready (o_job_ready),
        .i_x_job     (i_x_job),
        .i_w_job     (i_w_job),
        .o_start_mvm (o_start_mvm),
        .o_x_mvm     (o_x_mvm),
        .o_w_mvm     (o_w_mvm),
        .i_ismvm     (i_ismvm),
        .i_wx_result (i_wx_result),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_data  (o_res_data),
        .o_res_idx   (o_res_idx),
        .o_res_last  (o_res_last),
        .o_err       (o_err),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk_mvc = ~i_clk_mvc;

    initial begin
        #2000000;
        $display("FAIL global_time_limit");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- counters and scoreboard ----------------
    int n_vec   = 0;
    int n_err   = 0;
    int n_start = 0;
    logic [16+IDX_W:0] exp_q[$];   // {data, idx, last}

    always @(negedge i_clk_mvc) if (o_start_mvm === 1'b1) n_start++;

    // ---------------- engine model ----------------
    // After a start pulse the engine is busy for w+1 cycles; on busy cycle c
    // each lane reports x*c truncated to 4 bits.
    logic eng_en  = 1'b1;
    int   eng_rem = 0;
    int   eng_c   = 0;

    always @(negedge i_clk_mvc) begin
        if (i_rst_mvc || !eng_en) begin
            eng_rem = 0;
            i_ismvm = 1'b0;
        end else begin
            if (eng_rem > 0) begin
                int xv, p;
                eng_c++;
                i_ismvm = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    xv = int'($signed(o_x_mvm[4*k +: 4]));
                    p  = xv * eng_c;
                    i_wx_result[4*k +: 4] = p[3:0];
                end
                eng_rem--;
            end else begin
                i_ismvm = 1'b0;
            end
            if (o_start_mvm === 1'b1) begin
                eng_rem = int'(o_w_mvm) + 1;
                eng_c   = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] row_ref(input logic [15:0] x, input logic [3:0] w);
        logic [15:0] r;
        int          xv, p;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            xv = int'($signed(x[4*k +: 4]));
            p  = xv * (int'(w) + 1);
            r[4*k +: 4] = p[3:0];
        end
        return r;
    endfunction

    task automatic push_job(input logic [15:0] x, input logic [NUM_W*4-1:0] w);
        for (int r = 0; r < NUM_W; r++)
            exp_q.push_back({row_ref(x, w[4*r +: 4]), IDX_W'(r), (r == NUM_W - 1)});
    endtask

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk_mvc);
    endtask

    task automatic apply_job(input logic [15:0] x, input logic [NUM_W*4-1:0] w);
        int n = 0;
        while (o_job_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("job_ready_wait", o_job_ready, 1);
        i_job_valid = 1'b1;
        i_x_job     = x;
        i_w_job     = w;
        push_job(x, w);
        tick();
        i_job_valid = 1'b0;
        chk("start_after_accept", o_start_mvm, 1);
        chk("x_after_accept", o_x_mvm, x);
    endtask

    task automatic take_row(input int hold, input logic [15:0] cur_x);
        int              waited = 0;
        logic [16+IDX_W:0] e;
        logic            lst;
        while (o_res_valid !== 1'b1 && waited < 400) begin
            tick();
            waited++;
        end
        chk("res_valid_wait", o_res_valid, 1);
        if (o_res_valid !== 1'b1) return;
        chk("scoreboard_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        e   = exp_q.pop_front();
        lst = e[0];
        chk("res_data", o_res_data, e[16+IDX_W:1+IDX_W]);
        chk("res_idx", o_res_idx, e[IDX_W:1]);
        chk("res_last", o_res_last, lst);
        chk("x_stable", o_x_mvm, cur_x);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", o_res_valid, 1);
            chk("hold_data", o_res_data, e[16+IDX_W:1+IDX_W]);
            chk("hold_idx", o_res_idx, e[IDX_W:1]);
            chk("hold_no_start", o_start_mvm, 0);
        end
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        chk("handshake_next_start", o_start_mvm, !lst);
        if (lst) chk("idle_after_last", o_job_ready, 1);
    endtask

    function automatic logic [NUM_W*4-1:0] rand_w(input int lo, input int hi);
        logic [NUM_W*4-1:0] w;
        for (int r = 0; r < NUM_W; r++) w[4*r +: 4] = 4'($urandom_range(hi, lo));
        return w;
    endfunction

    // ---------------- directed / random sequence ----------------
    initial begin
        logic [15:0]        xa, xb;
        logic [NUM_W*4-1:0] wa, wb;
        int                 s0, seen, cnt;

        // reset behaviour
        i_rst_mvc = 1'b1;
        repeat (3) tick();
        chk("rst_job_ready", o_job_ready, 0);
        chk("rst_start", o_start_mvm, 0);
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_x", o_x_mvm, 0);
        chk("rst_w", o_w_mvm, 0);
        chk("rst_data", o_res_data, 0);
        i_rst_mvc = 1'b0;
        tick();
        chk("post_rst_ready", o_job_ready, 1);
        chk("post_rst_state", 32'(o_dbg_state), 32'(mvm_ctrl_pkg::ST_IDLE));

        // basic job x={1,2,3,4} w={3,5,0,7}; row 1 held 10 cycles before ready
        xa = 16'h4321;
        wa = 16'h7053;
        s0 = n_start;
        apply_job(xa, wa);
        take_row(0, xa);
        take_row(10, xa);
        take_row(0, xa);
        take_row(0, xa);
        chk("start_count", n_start - s0, NUM_W);

        // job offered while busy is ignored, then taken right after last row
        xa = 16'($urandom);
        wa = rand_w(1, 6);
        xb = 16'($urandom);
        wb = rand_w(0, 6);
        apply_job(xa, wa);
        i_job_valid = 1'b1;
        i_x_job     = xb;
        i_w_job     = wb;
        cnt = 0;
        while (i_ismvm !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("busy_seen", i_ismvm, 1);
        chk("busy_ready_low", o_job_ready, 0);
        for (int r = 0; r < NUM_W; r++) take_row(0, xa);
        push_job(xb, wb);
        tick();
        i_job_valid = 1'b0;
        chk("second_job_start", o_start_mvm, 1);
        chk("second_job_x", o_x_mvm, xb);
        for (int r = 0; r < NUM_W; r++) take_row(0, xb);

        // reset while row 2 is running
        xa = 16'($urandom);
        wa = rand_w(2, 15);
        apply_job(xa, wa);
        take_row(0, xa);
        take_row(0, xa);
        cnt = 0;
        while (i_ismvm !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        tick();
        chk("row2_weight", o_w_mvm, wa[11:8]);
        i_rst_mvc = 1'b1;
        tick();
        chk("midrst_ready", o_job_ready, 0);
        chk("midrst_start", o_start_mvm, 0);
        chk("midrst_valid", o_res_valid, 0);
        chk("midrst_err", o_err, 0);
        chk("midrst_x", o_x_mvm, 0);
        chk("midrst_w", o_w_mvm, 0);
        chk("midrst_data", o_res_data, 0);
        chk("midrst_state", 32'(o_dbg_state), 32'(mvm_ctrl_pkg::ST_IDLE));
        i_rst_mvc = 1'b0;
        exp_q.delete();
        tick();
        chk("midrst_idle_ready", o_job_ready, 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (o_res_valid === 1'b1) seen++;
            tick();
        end
        chk("midrst_no_result", seen, 0);

        // random jobs with random consumer back-pressure
        for (int j = 0; j < 4; j++) begin
            xa = 16'($urandom);
            wa = rand_w(0, 15);
            apply_job(xa, wa);
            for (int r = 0; r < NUM_W; r++) take_row($urandom_range(3, 0), xa);
        end

`ifdef MVM_CTRL_TIMEOUT_EN
        // engine never responds: watchdog aborts after TIMEOUT ARM cycles
        eng_en = 1'b0;
        xa = 16'($urandom);
        wa = rand_w(0, 15);
        apply_job(xa, wa);
        exp_q.delete();
        cnt  = 1;
        seen = 0;
        while (o_job_ready !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
            if (o_res_valid === 1'b1) seen++;
        end
        chk("wdog_abort_cycles", cnt, TIMEOUT + 2);
        chk("wdog_err_set", o_err, 1);
        chk("wdog_no_result", seen, 0);
        eng_en = 1'b1;
        xa = 16'($urandom);
        wa = rand_w(0, 5);
        apply_job(xa, wa);
        chk("wdog_err_cleared", o_err, 0);
        for (int r = 0; r < NUM_W; r++) take_row(0, xa);
`else
        chk("err_tied_low", o_err, 0);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mvm_ctrl.md
MVM_CTRL -- requirements
Module: mvm_ctrl

Interface
REQ-001 SHALL have parameter NUM_W, default 4, meaning weight rows per job (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 31, meaning max cycles per row in ARM+RUN (watchdog build only).
REQ-003 SHALL have port i_clk_mvc  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_rst_mvc  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_job_valid  input  1  job offered.
REQ-006 SHALL have port o_job_ready  output  1  controller accepts job.
REQ-007 SHALL have port i_x_job  input  4x4  four 4-bit signed BN inputs.
REQ-008 SHALL have port i_w_job  input  NUM_Wx4  weight rows.
REQ-009 SHALL have port o_start_mvm  output  1  one-cycle start pulse to MVM engine.
REQ-010 SHALL have port o_x_mvm  output  4x4  x vector to engine.
REQ-011 SHALL have port o_w_mvm  output  4  current weight to engine.
REQ-012 SHALL have port i_ismvm  input  1  engine busy/generating.
REQ-013 SHALL have port i_wx_result  input  4x4  engine accumulator outputs.
REQ-014 SHALL have port o_res_valid  output  1  result row offered.
REQ-015 SHALL have port i_res_ready  input  1  consumer accepts row.
REQ-016 SHALL have port o_res_data  output  4x4  captured row result.
REQ-017 SHALL have port o_res_idx  output  clog2(NUM_W) (min 1)  row index of o_res_data.
REQ-018 SHALL have port o_res_last  output  1  row is NUM_W-1.
REQ-019 SHALL have port o_err  output  1  sticky watchdog abort flag (0 without macro).

Function
REQ-020 SHALL have FSM states IDLE, LAUNCH, ARM, RUN, OUT.
REQ-021 SHALL drive o_job_ready=1 only in IDLE; job accepted on i_job_valid&&o_job_ready; x and all weights registered then; row index cleared to 0.
REQ-022 SHALL move IDLE->LAUNCH on accept; LAUNCH asserts o_start_mvm for exactly one cycle, then ARM.
REQ-023 SHALL hold o_x_mvm stable from accept until return to IDLE; o_w_mvm = registered weight[idx].
REQ-024 SHALL stay in ARM until i_ismvm=1, then RUN.
REQ-025 SHALL, in RUN, load capture register from i_wx_result every cycle i_ismvm=1; on first i_ismvm=0 go to OUT without loading that cycle.
REQ-026 SHALL, in OUT, hold o_res_valid=1 with stable data/idx/last until i_res_ready=1; on handshake go to IDLE if idx==NUM_W-1, else idx+1 and LAUNCH.
REQ-027 SHALL give job-accept-to-first-start latency of exactly 1 cycle; OUT handshake to next start also 1 cycle.
REQ-028 SHALL ignore i_job_valid outside IDLE; i_ismvm glitches outside ARM/RUN have no effect.
REQ-029 SHALL clear o_err on next job accept.

Reset
REQ-030 SHALL, on i_rst_mvc=1 at a clock edge, enter IDLE, clear idx, capture and job registers, drive o_start_mvm, o_res_valid, o_err, o_x_mvm, o_w_mvm, o_res_data to 0, o_job_ready 0 while reset high.
REQ-031 SHALL abandon any in-flight row on mid-operation reset; no result emitted for it.

Configuration
REQ-032 SHALL compile watchdog only when MVM_CTRL_TIMEOUT_EN is defined: counter clears on LAUNCH, counts cycles in ARM/RUN; reaching TIMEOUT aborts to IDLE, sets o_err, drops remaining rows, emits no result for aborted row.
REQ-033 SHALL, without MVM_CTRL_TIMEOUT_EN, wait indefinitely in ARM/RUN and tie o_err to 0.

Structure
REQ-034 SHALL place sn4_t (4-bit signed), vec4_t (4x sn4_t), NUM_LANES=4 and state enum in package mvm_ctrl_pkg.
REQ-035 SHALL implement watchdog as sub-module mvm_ctrl_wdog, instantiated only under the macro.

Verification
REQ-036 SHALL cover: NUM_W=4, x={1,2,3,4}, w={3,5,0,7}, engine model busy w+1 cycles -> 4 starts, rows idx 0..3, last only on idx 3, data = final busy-cycle sample.
REQ-037 SHALL cover: i_res_ready held 0 for 10 cycles in OUT -> o_res_valid and data stable, no new o_start_mvm.
REQ-038 SHALL cover: i_job_valid=1 during RUN -> o_job_ready=0, job ignored, second job accepted 1 cycle after last row handshake.
REQ-039 SHALL cover: i_rst_mvc asserted in RUN row 2 -> next cycle IDLE, all outputs 0, no result for row 2.
REQ-040 SHALL cover: with MVM_CTRL_TIMEOUT_EN, TIMEOUT=31, i_ismvm never rises -> after 31 ARM cycles o_err=1, IDLE, no o_res_valid; next accept clears o_err.
